// File: rtl/exp_cmd_queue_axil.sv
// AXI4-Lite command queue: CMD/DATA staging regs, FWFT command FIFO,
// result register with pending/overrun flags, NUM_IN status words.
// Ports: S_AXI_* AXI4-Lite slave; m_valid/m_ready/m_command/m_data queue head;
// i_result_valid/i_result result strobe; i_data_in packed status words.
// Optional: EXP_CMD_TIMESTAMP_EN adds per-entry push timestamps (m_timestamp, reg 7).
module exp_cmd_queue_axil #(
  parameter int C_AXI_ADDR_WIDTH = 6,
  parameter int LG_DEPTH = 2,
  parameter int CMD_W = 8,
  parameter int NUM_IN = 2
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  input  logic [31:0]                 S_AXI_WDATA,
  input  logic [3:0]                  S_AXI_WSTRB,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  output logic [1:0]                  S_AXI_BRESP,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [31:0]                 S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [CMD_W-1:0]            m_command,
  output logic [31:0]                 m_data,
`ifdef EXP_CMD_TIMESTAMP_EN
  output logic [31:0]                 m_timestamp,
`endif
  input  logic                        i_result_valid,
  input  logic [31:0]                 i_result,
  input  logic [32*NUM_IN-1:0]        i_data_in
);
  localparam int IW = C_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << LG_DEPTH;
  localparam int LW = LG_DEPTH + 1;
  localparam logic [31:0] CMD_MASK =
    (CMD_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CMD_W) - 64'd1);
  localparam logic [IW-1:0] A_CMD  = IW'(0);
  localparam logic [IW-1:0] A_DATA = IW'(1);
  localparam logic [IW-1:0] A_CTRL = IW'(2);
  localparam logic [IW-1:0] A_STAT = IW'(3);
  localparam logic [IW-1:0] A_RES  = IW'(4);
  localparam logic [IW-1:0] A_TS   = IW'(7);

  logic clk, rst_n;
  assign clk = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;

  logic awready_q, bvalid_q, rvalid_q;
  logic [31:0] rdata_q, rd_val;
  logic [31:0] cmd_q, data_q, result_q;
  logic pend_q, ovr_q, ovf_q;
  logic [LG_DEPTH-1:0] rp, wp, wa;
  logic [LW-1:0] level;
  logic [CMD_W-1:0] mem_cmd [DEPTH];
  logic [31:0] mem_dat [DEPTH];
  logic [31:0] ts_head;

  logic wr_fire, rd_fire, rd_res, ctrl_wr, stat_wr;
  logic push, flush, pop, push_ok, ovf_set, empty, full;
  logic [IW-1:0] wr_idx, rd_idx;

  function automatic logic [31:0] strb_merge(input logic [31:0] o,
      input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = s[i] ? w[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY = awready_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = 2'b00;

  assign wr_fire = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = S_AXI_ARVALID && !rvalid_q;
  assign wr_idx = S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
  assign rd_res = rd_fire && (rd_idx == A_RES);
  assign ctrl_wr = wr_fire && (wr_idx == A_CTRL) && S_AXI_WSTRB[0];
  assign stat_wr = wr_fire && (wr_idx == A_STAT) && S_AXI_WSTRB[2];
  assign push = ctrl_wr && S_AXI_WDATA[0];
  assign flush = ctrl_wr && S_AXI_WDATA[1];

  assign empty = (level == '0);
  assign full = (level == LW'(DEPTH));
  assign pop = !empty && m_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (flush || !full || pop);
  assign ovf_set = push && !flush && full && !pop;
  // After a flush the surviving new entry restarts at slot 0.
  assign wa = flush ? '0 : wp;

  assign m_valid = !empty;
  assign m_command = empty ? '0 : mem_cmd[rp];
  assign m_data = empty ? '0 : mem_dat[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      awready_q <= S_AXI_AWVALID && S_AXI_WVALID &&
                   (!bvalid_q || S_AXI_BREADY) && !awready_q;
      if (wr_fire) bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      data_q <= '0;
    end else begin
      if (wr_fire && wr_idx == A_CMD)
        cmd_q <= strb_merge(cmd_q, S_AXI_WDATA, S_AXI_WSTRB) & CMD_MASK;
      if (wr_fire && wr_idx == A_DATA)
        data_q <= strb_merge(data_q, S_AXI_WDATA, S_AXI_WSTRB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp <= '0;
      wp <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_cmd[i] <= '0;
        mem_dat[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_cmd[wa] <= cmd_q[CMD_W-1:0];
        mem_dat[wa] <= data_q;
      end
      if (flush) begin
        rp <= '0;
        wp <= push ? LG_DEPTH'(1) : '0;
        level <= push ? LW'(1) : '0;
      end else begin
        if (pop) rp <= rp + LG_DEPTH'(1);
        if (push_ok) wp <= wp + LG_DEPTH'(1);
        level <= level + LW'(push_ok) - LW'(pop);
      end
    end
  end

`ifdef EXP_CMD_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] mem_ts [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem_ts[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (push_ok) mem_ts[wa] <= ts_cnt;
    end
  end
  assign ts_head = empty ? '0 : mem_ts[rp];
  assign m_timestamp = ts_head;
`else
  assign ts_head = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      // Set events are applied after the W1C so they win.
      if (stat_wr && S_AXI_WDATA[18]) ovf_q <= 1'b0;
      if (stat_wr && S_AXI_WDATA[20]) ovr_q <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      if (i_result_valid) begin
        result_q <= i_result;
        pend_q <= 1'b1;
        // A same-cycle RESULT read consumes the old value: no overrun.
        if (pend_q && !rd_res) ovr_q <= 1'b1;
      end else if (rd_res) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      A_CMD: rd_val = cmd_q;
      A_DATA: rd_val = data_q;
      A_STAT: rd_val = {11'b0, ovr_q, pend_q, ovf_q, empty, full,
                        7'b0, 9'(level)};
      A_RES: rd_val = result_q;
      A_TS: rd_val = ts_head;
      default: begin
        for (int k = 0; k < NUM_IN; k++)
          if (rd_idx == IW'(8 + k)) rd_val = i_data_in[32*k +: 32];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q <= rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  logic unused;
  assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_exp_cmd_queue_axil.sv
// Testbench for exp_cmd_queue_axil: scoreboard of expected read data
// and expected FIFO entries, compared as the DUT produces them.
module tb_exp_cmd_queue_axil;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic awready, wready, bvalid, arready, rvalid;
  logic [5:0] awaddr = 0, araddr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic m_valid, m_ready = 0;
  logic [7:0] m_command;
  logic [31:0] m_data;
  logic res_v = 0;
  logic [31:0] res = 0;
  logic [63:0] din = {32'hCAFE_0001, 32'h1234_5678};
`ifdef EXP_CMD_TIMESTAMP_EN
  logic [31:0] m_ts;
`endif

  always #5 clk = ~clk;

  exp_cmd_queue_axil dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_command(m_command), .m_data(m_data),
`ifdef EXP_CMD_TIMESTAMP_EN
    .m_timestamp(m_ts),
`endif
    .i_result_valid(res_v), .i_result(res), .i_data_in(din)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] rd_q[$];
  logic [39:0] fifo_q[$];
  logic [31:0] mo_cmd = 0, mo_data = 0, mo_res = 0;
  bit mo_ovf = 0, mo_pend = 0, mo_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
      input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = s[i] ? w[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] stat_exp();
    int lvl = fifo_q.size();
    return {11'b0, mo_ovr, mo_pend, mo_ovf, lvl == 0, lvl == 4,
            7'b0, 9'(lvl)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      logic [39:0] e;
      e = (fifo_q.size() != 0) ? fifo_q.pop_front() : 40'hFF_BAD0_BAD0;
      check("pop_cmd", {24'b0, m_command}, {24'b0, e[39:32]});
      check("pop_data", m_data, e[31:0]);
    end
  end

  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit pop_now = 0);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (awready) break;
    end
    check("aw_handshake", 32'(awready && wready), 1);
    if (pop_now) m_ready = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    if (pop_now) m_ready = 0;
    case (a[5:2])
      4'd0: mo_cmd = merge(mo_cmd, d, s) & 32'hFF;
      4'd1: mo_data = merge(mo_data, d, s);
      4'd2: if (s[0]) begin
        if (d[1]) fifo_q.delete();
        if (d[0]) begin
          if (fifo_q.size() < 4) fifo_q.push_back({mo_cmd[7:0], mo_data});
          else mo_ovf = 1;
        end
      end
      4'd3: if (s[2]) begin
        if (d[18]) mo_ovf = 0;
        if (d[20]) mo_ovr = 0;
      end
      default: ;
    endcase
    for (int t = 0; t < 20; t++) begin
      if (bvalid) break;
      @(posedge clk); #1;
    end
    check("bvalid", {30'b0, bvalid, bresp == 2'b00}, 32'h3);
    @(posedge clk); #1;
  endtask

  task automatic axi_rd(input string tag, input logic [5:0] a,
                        input logic [31:0] exp, input bit res_now = 0,
                        input logic [31:0] res_val = 0);
    rd_q.push_back(exp);
    araddr = a; arvalid = 1;
    if (res_now) begin res_v = 1; res = res_val; end
    @(posedge clk); #1;
    arvalid = 0; res_v = 0;
    if (res_now) begin
      if (mo_pend && a[5:2] != 4'd4) mo_ovr = 1;
      mo_pend = 1; mo_res = res_val;
    end else if (a[5:2] == 4'd4) begin
      mo_pend = 0;
    end
    for (int t = 0; t < 20; t++) begin
      if (rvalid) break;
      @(posedge clk); #1;
    end
    check({tag, "_rvalid"}, {30'b0, rvalid, rresp == 2'b00}, 32'h3);
    check(tag, rdata, rd_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic pulse_res(input logic [31:0] v);
    res_v = 1; res = v;
    @(posedge clk); #1;
    res_v = 0;
    if (mo_pend) mo_ovr = 1;
    mo_pend = 1; mo_res = v;
  endtask

  task automatic drain(input int n);
    m_ready = 1;
    repeat (n) begin @(posedge clk); #1; end
    m_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {27'b0, m_valid, bvalid, rvalid, awready, wready}, 0);
    check("rst_head", {24'b0, m_command} | m_data, 0);
    rst_n = 1;
    @(posedge clk); #1;
    axi_rd("status_rst", 6'h0C, 32'h0002_0000);

    axi_wr(6'h00, 32'h5A, 4'hF);
    axi_wr(6'h04, 32'hDEAD_BEEF, 4'hF);
    axi_wr(6'h08, 32'h1, 4'h1);
    check("head_valid", 32'(m_valid), 1);
    check("head_cmd", {24'b0, m_command}, 32'h5A);
    check("head_data", m_data, 32'hDEAD_BEEF);
    axi_rd("status_l1", 6'h0C, stat_exp());

    axi_wr(6'h00, 32'hFFFF_FFFF, 4'hF);
    axi_rd("cmd_mask", 6'h00, mo_cmd);
    axi_wr(6'h04, 32'h1122_3344, 4'b0101);
    axi_rd("data_strb", 6'h04, mo_data);
    axi_rd("in0", 6'h20, 32'h1234_5678);
    axi_rd("in1", 6'h24, 32'hCAFE_0001);
    axi_rd("unmapped", 6'h14, 32'h0);
    axi_rd("ctrl_rd", 6'h08, 32'h0);
`ifndef EXP_CMD_TIMESTAMP_EN
    axi_rd("ts_off", 6'h1C, 32'h0);
`endif
    drain(3);
    check("empty_head", {23'b0, m_valid, m_command} | m_data, 0);

    for (int k = 1; k <= 5; k++) begin
      axi_wr(6'h00, 32'(k), 4'hF);
      axi_wr(6'h04, 32'h1000_0000 + 32'(k), 4'hF);
      axi_wr(6'h08, 32'h1, 4'h1);
    end
    axi_rd("status_full_ovf", 6'h0C, stat_exp());
    axi_wr(6'h0C, 32'h0004_0000, 4'b0100);
    axi_rd("status_w1c_ovf", 6'h0C, stat_exp());
    axi_wr(6'h08, 32'h1, 4'h1, 1);
    axi_rd("status_push_pop", 6'h0C, stat_exp());
    drain(6);
    axi_rd("status_drained", 6'h0C, stat_exp());

    pulse_res(32'h11);
    pulse_res(32'h22);
    axi_rd("status_ovr", 6'h0C, stat_exp());
    axi_rd("result", 6'h10, 32'h22);
    axi_rd("status_after_res", 6'h0C, stat_exp());
    axi_wr(6'h0C, 32'h0010_0000, 4'b0100);
    axi_rd("status_w1c_ovr", 6'h0C, stat_exp());
    pulse_res(32'h33);
    axi_rd("result_race", 6'h10, 32'h33, 1, 32'h44);
    axi_rd("status_race", 6'h0C, stat_exp());
    axi_rd("result_new", 6'h10, 32'h44);

    axi_wr(6'h00, 32'hA1, 4'hF);
    axi_wr(6'h08, 32'h1, 4'h1);
    axi_wr(6'h00, 32'hA2, 4'hF);
    axi_wr(6'h08, 32'h1, 4'h1);
    axi_wr(6'h00, 32'hC3, 4'hF);
    axi_wr(6'h04, 32'hC0FF_EE00, 4'hF);
    axi_wr(6'h08, 32'h3, 4'h1);
    axi_rd("status_flush_push", 6'h0C, stat_exp());
    check("flush_head", {24'b0, m_command}, 32'hC3);
    axi_wr(6'h08, 32'h2, 4'h0);
    axi_rd("status_nostrb", 6'h0C, stat_exp());
    drain(3);
    check("fifo_drained", 32'(fifo_q.size()) | 32'(m_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exp_cmd_queue_axil.md
Name: exp_cmd_queue_axil

Overview:
AXI4-Lite slave that stages experiment commands and queues them for the experiment controller. Each commit pushes a {command, data} pair into a parametrised FIFO instead of overwriting a single output register. The downstream side drains the FIFO over a valid/ready handshake and returns results into a result register with pending/overrun flags. NUM_IN experiment status words are readable over the bus.

Parameters:
C_AXI_ADDR_WIDTH, 6, byte address width; 16 word registers (ADDRLSB=2, data width fixed 32)
LG_DEPTH, 2, log2 of FIFO depth (depth 4); legal range 1..8
CMD_W, 8, command width, 1..32
NUM_IN, 2, number of 32-bit input status words, 1..8

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave channels  standard widths (ADDR C_AXI_ADDR_WIDTH, DATA 32, STRB 4, PROT 3, RESP 2); PROT ignored
m_valid  out  1  FIFO head valid
m_ready  in  1  downstream accepts head
m_command  out  CMD_W  head command
m_data  out  32  head data
i_result_valid  in  1  result strobe
i_result  in  32  result value
i_data_in  in  32*NUM_IN  status words, word k at [32k+:32]

Behaviour:
- Reset: asynchronous on S_AXI_ARESETN low. All registers, FIFO pointers and flags clear. BVALID, RVALID, m_valid, AWREADY and WREADY are 0. m_command and m_data are 0.
- Write path: AWREADY and WREADY pulse together for one cycle when AWVALID && WVALID && (!BVALID || BREADY) && !AWREADY. BVALID is set the next cycle and held until BREADY. BRESP is always 0.
- Read path: ARREADY = !RVALID. RDATA is registered; RVALID is asserted 1 cycle after the AR handshake and held until RREADY. RRESP is always 0.
- Register map (word index):
  - 0 CMD: RW, low CMD_W bits, byte strobes honoured; upper bits read 0.
  - 1 DATA: RW, 32 bits, byte strobes honoured.
  - 2 CTRL: W only, acts only if WSTRB[0]. bit0=push, bit1=flush. Reads 0.
  - 3 STATUS: RO except W1C bits.
    - [8:0] level.
    - bit16 full, bit17 empty.
    - bit18 fifo_overflow, sticky, W1C.
    - bit19 result_pending.
    - bit20 result_overrun, sticky, W1C.
  - 4 RESULT: RO; a read clears result_pending.
  - 7 TIMESTAMP: see Optional Feature.
  - 8..8+NUM_IN-1 IN[k]: RO, returns i_data_in word k sampled at AR acceptance.
  - Unmapped addresses: reads return 0, writes are ignored.
- FIFO: first-word-fall-through, depth 2^LG_DEPTH, storing {CMD, DATA} as they stand before the CTRL write.
  - m_valid = !empty. m_command and m_data are 0 when empty.
  - A pop occurs on m_valid && m_ready; the next entry appears the following cycle.
  - Push is accepted if !full, or if full with a pop in the same cycle; level is then unchanged.
  - Push while full with no pop: the entry is dropped and fifo_overflow is set.
  - Flush: empties the FIFO in the write cycle. A concurrent pop handshake still completes and is counted as consumed.
  - Flush and push in the same write: the FIFO ends holding only the new entry (level 1).
  - Pointers wrap modulo depth. Level is held in LG_DEPTH+1 bits.
- Result:
  - i_result_valid loads RESULT and sets result_pending.
  - If result_pending is already 1, the new value overwrites RESULT and result_overrun is set.
  - RESULT read accepted in the same cycle as i_result_valid: the new value wins, pending stays 1, overrun is not set. The read returns the old value.
- STATUS W1C with WSTRB[2]: bit18/bit20 are cleared when written 1. A set event in the same cycle takes priority over the clear.

Optional Feature:
EXP_CMD_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter runs from reset, wraps at 2^32 and resets to 0.
  - Each pushed entry captures the counter value on its push cycle.
  - Register 7 returns the head entry's timestamp, or 0 when empty.
  - Output port m_timestamp (32) is added.
- Undefined: no counter and no port; register 7 reads 0.

Test Plan:
- Reset then read STATUS -> 0x0002_0000 (empty); m_valid=0; BVALID=RVALID=0.
- Write CMD=0x5A, DATA=0xDEADBEEF, CTRL=1; hold m_ready=0 -> m_valid=1, m_command=0x5A, m_data=0xDEADBEEF, STATUS level=1.
- LG_DEPTH=2: push 5 entries with m_ready=0 -> level=4, full=1, bit18=1, fifo keeps the first 4. Write STATUS 0x40000 with WSTRB=4'b0100 -> bit18=0.
- FIFO full, m_ready=1 held during a push -> push accepted, level stays 4, no overflow. Data pops in order 1,2,3,4,5.
- i_result_valid with 0x11, then 0x22 -> STATUS bits19,20 =1. Read RESULT=0x22 -> pending=0, overrun stays 1.
- Write CTRL=3 with 2 entries queued -> level=1, head = current CMD/DATA. Write CTRL=2 with WSTRB=0 -> no effect.
